// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream to instruction RAM word writer with checksum gate
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_rst_n
);

  localparam int IW = $clog2(MAX_WORDS) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_next;

  logic [1:0]    byte_cnt;
  logic [31:0]   n_words;
  logic [23:0]   word_sr;
  logic [IW-1:0] idx;
  logic [7:0]    csum;

  logic          take;
  logic          go;
  logic          last_byte;
  logic          last_word;
  logic [31:0]   hdr_n;
  logic [31:0]   idx_ext;

  assign take      = rx_valid && rx_ready;
  assign go        = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign last_byte = (byte_cnt == 2'd3);
  // Header value including the byte arriving this cycle (little-endian shift-in).
  assign hdr_n     = {rx_data, n_words[31:8]};
  assign idx_ext   = {{(32-IW){1'b0}}, idx};
  assign last_word = ((idx_ext + 32'd1) == n_words);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_next = S_HDR;
      end
      S_HDR: begin
        if (take && last_byte) begin
          if (hdr_n > MAX_WORDS)  state_next = S_ERR;
          else if (hdr_n == 32'd0) state_next = S_CSUM;
          else                     state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (take && last_byte && last_word) state_next = S_CSUM;
      end
      S_CSUM: begin
        if (take) state_next = (rx_data == csum) ? S_DONE : S_ERR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rx_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_rst_n <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_din   <= 32'd0;
      byte_cnt  <= 2'd0;
      n_words   <= 32'd0;
      word_sr   <= 24'd0;
      idx       <= '0;
      csum      <= 8'd0;
    end else begin
      state     <= state_next;
      // Status flags are decoded from the next state so they are clean flop outputs.
      rx_ready  <= state_next inside {S_HDR, S_DATA, S_CSUM};
      busy      <= state_next inside {S_HDR, S_DATA, S_CSUM};
      done      <= (state_next == S_DONE);
      error     <= (state_next == S_ERR);
      cpu_rst_n <= (state_next == S_DONE);
      mem_we    <= 1'b0;
      if (go) begin
        byte_cnt <= 2'd0;
        n_words  <= 32'd0;
        idx      <= '0;
        csum     <= 8'd0;
      end else if (take) begin
        if (state != S_CSUM) begin
          csum     <= csum ^ rx_data;
          byte_cnt <= byte_cnt + 2'd1;
        end
        if (state == S_HDR) n_words <= hdr_n;
        if (state == S_DATA) begin
          word_sr <= {rx_data, word_sr[23:8]};
          if (last_byte) begin
            mem_we   <= 1'b1;
            mem_din  <= {rx_data, word_sr};
            mem_addr <= BASE_ADDR + (idx_ext << 2);
            idx      <= idx + IW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader against a frame-level model
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int unsigned MAXW = 1024;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_rst_n;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .busy(busy), .done(done), .error(error), .cpu_rst_n(cpu_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_hs = 0;
  int we_run = 0;
  int pulse_viol = 0;
  int ready_viol = 0;

  logic [31:0] got_addr[$];
  logic [31:0] got_din[$];
  int          got_cyc[$];
  logic [31:0] words[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port and handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_addr.push_back(mem_addr);
      got_din.push_back(mem_din);
      got_cyc.push_back(cyc);
      we_run = we_run + 1;
      if (we_run > 1) pulse_viol = pulse_viol + 1;
    end else begin
      we_run = 0;
    end
    if (rx_ready === 1'b1 && busy !== 1'b1) ready_viol = ready_viol + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int pct);
    bit took;
    int guard;
    took = 0;
    guard = 0;
    while (!took && guard < 200) begin
      rx_data  = b;
      rx_valid = ($urandom_range(99) < pct);
      @(negedge clk);
      took = rx_valid && rx_ready;
      if (took) last_hs = cyc;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!took) begin
      total++; bad++;
      $display("FAIL send_byte_timeout byte=%02h not accepted within 200 cycles", b);
    end
  endtask

  task automatic load(input logic [31:0] n_hdr, input logic [7:0] cmask, input int pct, input int start_at);
    logic [7:0] bytes[$];
    logic [7:0] x;
    int exp_cyc[$];
    int n;
    bytes = {};
    x = 8'd0;
    n = words.size();
    for (int k = 0; k < 4; k++) bytes.push_back(n_hdr[8*k +: 8]);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) bytes.push_back(words[i][8*k +: 8]);
    foreach (bytes[i]) x = x ^ bytes[i];
    x = x ^ cmask;
    got_addr = {}; got_din = {}; got_cyc = {};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (rx_ready !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL start_to_ready: rx_ready=%b busy=%b want 1 1", rx_ready, busy);
    end
    for (int i = 0; i < bytes.size(); i++) begin
      if (i == start_at) start = 1'b1;
      send_byte(bytes[i], pct);
      start = 1'b0;
      if (i >= 4 && ((i - 4) % 4) == 3) exp_cyc.push_back(last_hs + 1);
    end
    send_byte(x, pct);
    rx_valid = 1'b0;
    total++;
    if (done !== (cmask == 0) || error !== (cmask != 0) || cpu_rst_n !== (cmask == 0) ||
        busy !== 1'b0 || rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL outcome: done=%b error=%b cpu_rst_n=%b busy=%b rx_ready=%b want done=%b error=%b",
               done, error, cpu_rst_n, busy, rx_ready, cmask == 0, cmask != 0);
    end
    total++;
    if (got_addr.size() != n) begin
      bad++;
      $display("FAIL write_count: got %0d want %0d", got_addr.size(), n);
    end
    for (int i = 0; i < n && i < got_addr.size(); i++) begin
      total++;
      if (got_addr[i] !== BASE + 32'(4 * i) || got_din[i] !== words[i] || got_cyc[i] != exp_cyc[i]) begin
        bad++;
        $display("FAIL write[%0d]: addr=%h din=%h cyc=%0d want addr=%h din=%h cyc=%0d",
                 i, got_addr[i], got_din[i], got_cyc[i], BASE + 32'(4 * i), words[i], exp_cyc[i]);
      end
    end
    if (n > 0) begin
      total++;
      if (mem_addr !== BASE + 32'(4 * (n - 1)) || mem_din !== words[n-1]) begin
        bad++;
        $display("FAIL write_hold: addr=%h din=%h want %h %h", mem_addr, mem_din,
                 BASE + 32'(4 * (n - 1)), words[n-1]);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (rx_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== BASE || mem_din !== 32'd0 ||
        busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || cpu_rst_n !== 1'b0) begin
      bad++;
      $display("FAIL %s: rdy=%b we=%b addr=%h din=%h busy=%b done=%b err=%b cpu=%b want all reset values",
               tag, rx_ready, mem_we, mem_addr, mem_din, busy, done, error, cpu_rst_n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; rx_valid = 1'b0; rx_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_values");
    start = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_beats_start: busy=%b rx_ready=%b want 0 0", busy, rx_ready);
    end
  endtask

  task automatic test_basic();
    words = {32'h0000_0013, 32'hDEAD_BEEF};
    load(32'd2, 8'h00, 100, -1);
    total++;
    if (got_cyc.size() == 2 ? (got_cyc[1] - got_cyc[0] != 4) : 1'b1) begin
      bad++;
      $display("FAIL back_to_back_spacing: writes=%0d want 2 writes 4 cycles apart", got_cyc.size());
    end
  endtask

  task automatic test_zero_words();
    words = {};
    load(32'd0, 8'h00, 100, -1);
    load(32'd0, 8'h01, 100, -1);
  endtask

  task automatic test_oversize();
    got_addr = {};
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    send_byte(8'h01, 100); send_byte(8'h04, 100); send_byte(8'h00, 100); send_byte(8'h00, 100);
    rx_valid = 1'b0;
    total++;
    if (error !== 1'b1 || rx_ready !== 1'b0 || busy !== 1'b0 || cpu_rst_n !== 1'b0 || got_addr.size() != 0) begin
      bad++;
      $display("FAIL oversize_1025: error=%b rx_ready=%b busy=%b cpu=%b writes=%0d want 1 0 0 0 0",
               error, rx_ready, busy, cpu_rst_n, got_addr.size());
    end
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    total++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_from_err: error=%b busy=%b want 0 1", error, busy);
    end
    send_byte(8'h00, 100); send_byte(8'h04, 100); send_byte(8'h00, 100); send_byte(8'h00, 100);
    rx_valid = 1'b0;
    total++;
    if (error !== 1'b0 || rx_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL max_words_accepted: error=%b rx_ready=%b busy=%b done=%b want 0 1 1 0",
               error, rx_ready, busy, done);
    end
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_toggle_valid();
    words = {$urandom()};
    load(32'd1, 8'h00, 50, -1);
  endtask

  task automatic test_bad_csum_recover();
    words = {$urandom(), $urandom(), $urandom()};
    load(32'd3, 8'($urandom_range(255, 1)), 100, -1);
    words = {$urandom(), $urandom()};
    load(32'd2, 8'h00, 100, -1);
  endtask

  task automatic test_start_ignored();
    words = {$urandom(), $urandom()};
    load(32'd2, 8'h00, 100, 6);
  endtask

  task automatic test_reset_mid();
    words = {$urandom(), $urandom(), $urandom(), $urandom()};
    got_addr = {};
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    send_byte(8'h04, 100); send_byte(8'h00, 100); send_byte(8'h00, 100); send_byte(8'h00, 100);
    for (int j = 0; j < 6; j++) send_byte(words[j/4][8*(j%4) +: 8], 100);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("reset_mid_load");
    total++;
    if (got_addr.size() != 1) begin
      bad++;
      $display("FAIL writes_before_reset: got %0d want 1", got_addr.size());
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    words = {$urandom(), $urandom()};
    load(32'd2, 8'h00, 100, -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n;
      logic [7:0] cm;
      n = $urandom_range(6, 1);
      words = {};
      for (int i = 0; i < n; i++) words.push_back($urandom());
      cm = ($urandom_range(2) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      load(32'(n), cm, $urandom_range(100, 40), -1);
    end
  endtask

  task automatic test_monitors();
    total++;
    if (pulse_viol != 0) begin
      bad++;
      $display("FAIL mem_we_single_cycle: %0d multi-cycle pulses want 0", pulse_viol);
    end
    total++;
    if (ready_viol != 0) begin
      bad++;
      $display("FAIL ready_outside_busy: %0d cycles want 0", ready_viol);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_words();
    test_oversize();
    test_toggle_valid();
    test_bad_csum_recover();
    test_start_ignored();
    test_reset_mid();
    test_random();
    test_monitors();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the 4 KB instruction RAM: receives a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit words and drives the RAM write port (`we`/`addr`/`din`) one word per write. It sits between the host byte source (UART RX or debug link) and the instruction memory. It holds the CPU in reset until a complete, checksum-verified image has been written.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first word written; must be word-aligned.
- `MAX_WORDS`, default 1024: largest accepted image in words, matching the RAM depth.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  single-cycle pulse that begins a load.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  RAM write enable, one-cycle pulse per word.
- `mem_addr`  out  32  RAM byte address, word-aligned (RAM indexes with `addr[11:2]`).
- `mem_din`  out  32  RAM write data.
- `busy`  out  1  high in HDR, DATA and CSUM.
- `done`  out  1  image loaded and verified; sticky.
- `error`  out  1  load failed; sticky.
- `cpu_rst_n`  out  1  CPU reset, low until `done`.

## Operation
- Frame format:
  - 4-byte word count N, little-endian.
  - N×4 data bytes, each word little-endian: byte k of a word goes to bits [8k+7:8k].
  - 1 checksum byte equal to the XOR of all preceding header and data bytes.
- A byte is accepted on any cycle with `rx_valid && rx_ready`. `rx_ready` is a registered function of state: high in HDR, DATA and CSUM, low otherwise.
- States:
  - IDLE: on `start` → HDR. Clear byte counter, word index and checksum accumulator.
  - HDR: accept 4 bytes into N.
    - On the 4th byte: if N > MAX_WORDS → ERR.
    - Else if N == 0 → CSUM.
    - Else → DATA.
  - DATA: accept bytes into a word shift register.
    - On the 4th byte of a word: register `mem_din` = assembled word and `mem_addr` = BASE_ADDR + 4×idx, pulse `mem_we`, then increment idx.
    - After word N-1 → CSUM.
  - CSUM: accept 1 byte. If it equals the accumulator → DONE, else → ERR.
  - DONE: `done`=1, `cpu_rst_n`=1. On `start` → HDR and clear `done`/`cpu_rst_n` (the CPU is re-held in reset).
  - ERR: `error`=1, `cpu_rst_n`=0. On `start` → HDR and clear `error`.
- `start` is ignored in HDR, DATA and CSUM.
- The checksum accumulator XORs every accepted byte in HDR and DATA. The checksum byte itself is excluded.
- Word index width: clog2(MAX_WORDS)+1 bits. The N comparison uses the full 32 bits.

## Timing
- Reset values:
  - `rx_ready`=0, `mem_we`=0, `mem_addr`=BASE_ADDR, `mem_din`=0.
  - `busy`=0, `done`=0, `error`=0, `cpu_rst_n`=0.
  - State IDLE.
- `start` in cycle t → `rx_ready`=1 and `busy`=1 in cycle t+1.
- Write latency: handshake of a word's 4th byte in cycle t → `mem_we`=1 with valid `mem_addr`/`mem_din` in cycle t+1, for exactly one cycle. `mem_addr`/`mem_din` hold their values until the next write.
- Throughput: one byte per cycle with `rx_valid` held high. Back-to-back words produce a `mem_we` every 4th cycle. No stall is required because the RAM accepts a write every cycle.
- Final data byte: the handshake in cycle t moves the state to CSUM at t+1, coincident with the last `mem_we`.
- Checksum byte: the handshake in cycle t → `done`/`cpu_rst_n` or `error` high at t+1. `busy` and `rx_ready` are low at t+1.
- `rx_valid` low stalls the byte counter indefinitely. There is no timeout.
- `rst_n` low mid-load: at the next edge every output returns to its reset value. A partially assembled word is discarded. Words already written stay in the RAM.
- `start` coincident with `rst_n` low: reset wins.

## Test plan
- N=2, words 0x0000_0013 and 0xDEAD_BEEF, correct checksum, `rx_valid` held high → `mem_we` pulses twice, 4 cycles apart:
  - addr 0x0 / din 0x0000_0013;
  - addr 0x4 / din 0xDEAD_BEEF;
  - `done`=1 and `cpu_rst_n`=1 the cycle after the checksum byte.
- N=0, checksum 0x00 → no `mem_we`, `done`=1. Checksum 0x01 instead → `error`=1, `cpu_rst_n`=0.
- N=1025 (header bytes 01 04 00 00) with MAX_WORDS=1024 → ERR after the 4th header byte, `rx_ready`=0, no writes.
- N=1 with `rx_valid` toggled randomly and BASE_ADDR=0x100 → a single write at addr 0x100 with the correct word. `rx_ready` is never high outside HDR/DATA/CSUM.
- Corrupted checksum on N=3 → three writes occur, then `error`=1 and `cpu_rst_n` stays 0. A following `start` plus a valid frame → `done`=1 and `error`=0.
- `rst_n` low after the 6th data byte of N=4 → all outputs at their reset values next cycle. A new `start` plus a full frame rewrites from BASE_ADDR.
